microwave_countdown_timer: RTL

MICROWAVE_COUNTDOWN_TIMER -- requirements
Module: microwave_countdown_timer

---
 rtl/microondas_pkg.sv | 28 ++
 rtl/bcd_digit_down.sv | 26 ++
 rtl/microwave_countdown_timer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave countdown timer: state encoding,
// BCD digit width and the per-digit limits used for clamping and borrow.
package microondas_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned SEC_T_MAX = 5;
    localparam int unsigned SEC_O_MAX = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min;
        logic [DIGIT_W-1:0] sec_t;
        logic [DIGIT_W-1:0] sec_o;
    } bcd_time_t;

    // Saturate a captured digit to its legal maximum
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: decrements when enabled, wrapping
// from 0 to wrap_val and raising borrow_out for the next digit up.
module bcd_digit_down
    import microondas_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               dec_en,
    input  logic [DIGIT_W-1:0] wrap_val,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (dec_en) begin
            if (digit == '0) begin
                next_digit = wrap_val;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/microwave_countdown_timer.sv
// M:SS BCD countdown timer with load/start/pause/clear control and a
// one-cycle done pulse when the count reaches 0:00.
module microwave_countdown_timer
    import microondas_pkg::*;
#(
    parameter int unsigned MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] in_min,
    input  logic [3:0] in_sec_t,
    input  logic [3:0] in_sec_o,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] min,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       done
);

    localparam logic [DIGIT_W-1:0] MIN_LIM   = DIGIT_W'(MAX_MIN);
    localparam logic [DIGIT_W-1:0] SEC_T_LIM = DIGIT_W'(SEC_T_MAX);
    localparam logic [DIGIT_W-1:0] SEC_O_LIM = DIGIT_W'(SEC_O_MAX);

    state_e    state_q, state_d;
    bcd_time_t time_q, time_d;
    logic      running_q, running_d;
    logic      done_q, done_d;

    logic [DIGIT_W-1:0] dec_min, dec_sec_t, dec_sec_o;
    logic               borrow_o, borrow_t, borrow_m;
    logic               time_zero;
    logic               dec_zero;

    // Borrow chain computing time_q minus one second
    bcd_digit_down u_sec_o (
        .digit      (time_q.sec_o),
        .dec_en     (tick),
        .wrap_val   (SEC_O_LIM),
        .next_digit (dec_sec_o),
        .borrow_out (borrow_o)
    );

    bcd_digit_down u_sec_t (
        .digit      (time_q.sec_t),
        .dec_en     (borrow_o),
        .wrap_val   (SEC_T_LIM),
        .next_digit (dec_sec_t),
        .borrow_out (borrow_t)
    );

    bcd_digit_down u_min (
        .digit      (time_q.min),
        .dec_en     (borrow_t),
        .wrap_val   ('0),
        .next_digit (dec_min),
        .borrow_out (borrow_m)
    );

    assign time_zero = (time_q == '0);
    assign dec_zero  = ({dec_min, dec_sec_t, dec_sec_o} == '0);

    // Next state: clear > load > pause/start > tick
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            time_d  = '0;
        end else if (load && (state_q != RUN)) begin
            state_d      = IDLE;
            time_d.min   = clamp_digit(in_min,   MIN_LIM);
            time_d.sec_t = clamp_digit(in_sec_t, SEC_T_LIM);
            time_d.sec_o = clamp_digit(in_sec_o, SEC_O_LIM);
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (start && !time_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick && !borrow_m) begin
                        // borrow out of minutes would mean underflow past 0:00
                        time_d.min   = dec_min;
                        time_d.sec_t = dec_sec_t;
                        time_d.sec_o = dec_sec_o;
                        if (dec_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            time_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign min     = time_q.min;
    assign sec_t   = time_q.sec_t;
    assign sec_o   = time_q.sec_o;
    assign running = running_q;
    assign done    = done_q;

endmodule
